// File: rtl/bitty_ctrl_seq.sv
// bitty_ctrl_seq: multi-cycle control sequencer feeding the bitty operand mux.
// Accepts one instruction per run handshake in IDLE, then steps through
// S_LOAD -> C_LOAD -> WB -> DONE (illegal formats go straight to DONE).
// All outputs are decoded from the state and latched-instruction registers.
// Optional feature macro: BITTY_CTRL_ILLEGAL_EN adds the 'illegal' output,
// flagged together with done when an illegal format was retired.
module bitty_ctrl_seq #(
    parameter bit         IMM_SIGNED = 1'b0,
    parameter logic [3:0] DEF_SEL    = 4'd9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] instr,
    output logic        busy,
    output logic        done,
    output logic [3:0]  mux_sel,
    output logic        en_s,
    output logic        en_c,
    output logic [7:0]  en_rf,
    output logic [2:0]  alu_sel,
    output logic [15:0] imm_out
`ifdef BITTY_CTRL_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_LOAD = 3'd1,
        C_LOAD = 3'd2,
        WB     = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;

    // Field views of the latched instruction
    logic [2:0] rx_q;
    logic [2:0] ry_q;
    logic [7:0] imm8_q;
    logic [1:0] fmt_q;

    assign rx_q   = instr_q[15:13];
    assign ry_q   = instr_q[12:10];
    assign imm8_q = instr_q[12:5];
    assign fmt_q  = instr_q[1:0];

    // State and instruction registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Next-state: run is only looked at in IDLE, so later requests are dropped
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    instr_d = instr;
                    if (instr[1]) begin
                        state_d = DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_d = C_LOAD;
            C_LOAD:  state_d = WB;
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode; mux parks on DEF_SEL whenever no operand is selected
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        mux_sel = DEF_SEL;
        en_s    = 1'b0;
        en_c    = 1'b0;
        en_rf   = 8'h00;
        case (state_q)
            S_LOAD: begin
                busy    = 1'b1;
                mux_sel = {1'b0, rx_q};
                en_s    = 1'b1;
            end
            C_LOAD: begin
                busy = 1'b1;
                en_c = 1'b1;
                if (fmt_q[0]) begin
                    mux_sel = 4'd8;
                end else begin
                    mux_sel = {1'b0, ry_q};
                end
            end
            WB: begin
                busy  = 1'b1;
                en_rf = 8'h01 << rx_q;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Opcode and immediate come straight from the latched instruction
    always_comb begin
        alu_sel = instr_q[4:2];
        if (IMM_SIGNED) begin
            imm_out = {{8{imm8_q[7]}}, imm8_q};
        end else begin
            imm_out = {8'h00, imm8_q};
        end
    end

`ifdef BITTY_CTRL_ILLEGAL_EN
    // Illegal flag accompanies done only when the retired format was 1x
    always_comb begin
        illegal = (state_q == DONE) && fmt_q[1];
    end
`endif

endmodule
